// File: rtl/config_seq_pkg.sv
// Shared definitions for the configuration frame sequencer: controller state
// encoding, bitstream control words and the header field position.
package config_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_STROBE = 3'd4
  } cfg_state_e;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // The frame index sits in the least significant bits of a header word.
  localparam int HDR_IDX_LSB = 0;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered frame-index to one-hot decoder. Produces a single-cycle commit
// pulse when enabled; an index with no matching frame yields all zeros.
module frame_strobe_decoder #(
  parameter int NumFrames = 20,
  parameter int IdxW      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [IdxW-1:0]      idx,
  output logic [NumFrames-1:0] strobe
);

  logic [NumFrames-1:0] strobe_d;
  logic [NumFrames-1:0] strobe_q;

  // Decode the index; out-of-range indices match no bit.
  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < NumFrames; i++) begin
      strobe_d[i] = en && (int'(idx) == i);
    end
  end

  // Register the pulse so the strobe is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_q <= '0;
    else        strobe_q <= strobe_d;
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/config_frame_sequencer.sv
// Configuration-load controller for one fabric column. Hunts for the sync
// word, then for each frame takes a header (frame index) followed by one
// data word per row, pulses RowSelect per row and finally commits the frame
// with a one-hot FrameStrobe.
module config_frame_sequencer
  import config_seq_pkg::*;
#(
  parameter int FrameBitsPerRow  = 32,
  parameter int RowSelectWidth   = 5,
  parameter int NumberOfRows     = 10,
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [31:0]                 WriteData,
  input  logic                        WriteValid,
  output logic                        WriteReady,
  output logic [FrameBitsPerRow-1:0]  FrameData_O,
  output logic [RowSelectWidth-1:0]   RowSelect,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                        Busy,
  output logic                        ErrorFlag
);

  cfg_state_e                  state_d, state_q;
  logic                        write_ready_d, write_ready_q;
  logic [FrameBitsPerRow-1:0]  frame_data_d, frame_data_q;
  logic [RowSelectWidth-1:0]   row_sel_d, row_sel_q;
  logic [RowSelectWidth-1:0]   row_cnt_d, row_cnt_q;
  logic [FrameSelectWidth-1:0] frame_idx_d, frame_idx_q;
  logic                        frame_valid_d, frame_valid_q;
  logic                        busy_d, busy_q;
  logic                        error_d, error_q;
  logic                        accept;
  logic                        strobe_en;
  logic [FrameSelectWidth-1:0] hdr_idx;

  assign accept  = WriteValid && write_ready_q;
  assign hdr_idx = WriteData[HDR_IDX_LSB +: FrameSelectWidth];

  // Next-state and next-output logic; every output is derived from the
  // state being entered so it can be registered.
  always_comb begin
    state_d       = state_q;
    frame_data_d  = frame_data_q;
    row_sel_d     = '0;
    row_cnt_d     = row_cnt_q;
    frame_idx_d   = frame_idx_q;
    frame_valid_d = frame_valid_q;
    error_d       = error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && WriteData == SYNC_WORD) begin
          state_d = ST_HEADER;
          error_d = 1'b0;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          if (WriteData == DESYNC_WORD) begin
            state_d = ST_IDLE;
          end else if (WriteData != SYNC_WORD) begin
            // A bad index still consumes the frame's rows but never commits.
            frame_idx_d   = hdr_idx;
            frame_valid_d = int'(hdr_idx) < MaxFramesPerCol;
            if (int'(hdr_idx) >= MaxFramesPerCol) error_d = 1'b1;
            row_cnt_d = RowSelectWidth'(1);
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // No sync detection here: every accepted word is row data.
        if (accept) begin
          frame_data_d = FrameBitsPerRow'(WriteData);
          row_sel_d    = row_cnt_q;
          row_cnt_d    = row_cnt_q + RowSelectWidth'(1);
          if (row_cnt_q == RowSelectWidth'(NumberOfRows)) state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HEADER;
      default:   state_d = ST_IDLE;
    endcase
    write_ready_d = (state_d == ST_IDLE) || (state_d == ST_HEADER) ||
                    (state_d == ST_DATA);
    busy_d        = (state_d != ST_IDLE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      write_ready_q <= 1'b1;
      frame_data_q  <= '0;
      row_sel_q     <= '0;
      row_cnt_q     <= '0;
      frame_idx_q   <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_ready_q <= write_ready_d;
      frame_data_q  <= frame_data_d;
      row_sel_q     <= row_sel_d;
      row_cnt_q     <= row_cnt_d;
      frame_idx_q   <= frame_idx_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      error_q       <= error_d;
    end
  end

  // The strobe is loaded while leaving SETTLE so it is visible in STROBE.
  assign strobe_en = (state_q == ST_SETTLE) && frame_valid_q;

  frame_strobe_decoder #(
    .NumFrames (MaxFramesPerCol),
    .IdxW      (FrameSelectWidth)
  ) u_strobe_dec (
    .clk    (CLK),
    .rst_n  (resetn),
    .en     (strobe_en),
    .idx    (frame_idx_q),
    .strobe (FrameStrobe)
  );

  assign WriteReady  = write_ready_q;
  assign FrameData_O = frame_data_q;
  assign RowSelect   = row_sel_q;
  assign Busy        = busy_q;
  assign ErrorFlag   = error_q;

endmodule
